// File: rtl/subleq_pkg.sv
// Shared types and defaults for the SUBLEQ one-instruction core.
package subleq_pkg;

  localparam int unsigned SUBLEQ_ADDR_W    = 8;
  localparam int unsigned SUBLEQ_DATA_W    = 8;
  localparam logic [7:0]  SUBLEQ_HALT_ADDR = 8'hFF;
  localparam int unsigned SUBLEQ_INSTR_LEN = 3;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_F1    = 3'd1,
    ST_F2    = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } subleq_state_e;

endpackage

// File: rtl/subleq_alu.sv
// Combinational SUBLEQ datapath: wrapped subtract and the "result <= 0" flag.
module subleq_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] opb,
  input  logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] diff,
  output logic              leq
);

  // The flag looks at the truncated result, so overflow can flip the branch.
  always_comb begin
    diff = opb - opa;
    leq  = diff[DATA_W-1] | (diff == '0);
  end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ sequencer: fetches a,b,c over two registered RAM read ports, writes
// mem[b]-mem[a] back to b and branches to c when the result is <= 0.
module subleq_ctrl
  import subleq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = SUBLEQ_ADDR_W,
  parameter int unsigned       DATA_W    = SUBLEQ_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(SUBLEQ_HALT_ADDR)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  output logic [ADDR_W-1:0] addrA,
  output logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  output logic [ADDR_W-1:0] addrC,
  output logic [DATA_W-1:0] dataC,
  output logic              WE,
  output logic [ADDR_W-1:0] PC,
  output logic              INSTR_DONE,
  output logic              HALTED,
  output subleq_state_e     state_o
);

  subleq_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic [DATA_W-1:0] opb_q, opb_d;

  logic [DATA_W-1:0] diff;
  logic              leq;

  subleq_alu #(.DATA_W(DATA_W)) u_alu (
    .opb  (opb_q),
    .opa  (dataA),
    .diff (diff),
    .leq  (leq)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
      opb_q   <= opb_d;
    end
  end

  // Read data arrives one cycle after its address, so each state captures
  // what the previous state asked for and issues the next request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    c_ptr_d = c_ptr_q;
    opb_d   = opb_q;
    addrA   = pc_q;
    addrB   = pc_q + ADDR_W'(1);
    addrC   = '0;
    dataC   = '0;
    WE      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (RUN) state_d = ST_F1;
      end
      ST_F1: begin
        a_ptr_d = ADDR_W'(dataA);
        b_ptr_d = ADDR_W'(dataB);
        addrA   = pc_q + ADDR_W'(2);
        addrB   = ADDR_W'(dataB);
        state_d = ST_F2;
      end
      ST_F2: begin
        c_ptr_d = ADDR_W'(dataA);
        opb_d   = dataB;
        addrA   = a_ptr_q;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        WE    = ~RST;
        addrC = b_ptr_q;
        dataC = diff;
        if (leq && (c_ptr_q == HALT_ADDR)) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = leq ? c_ptr_q : pc_q + ADDR_W'(SUBLEQ_INSTR_LEN);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign PC         = pc_q;
  assign INSTR_DONE = (state_q == ST_EXEC);
  assign HALTED     = (state_q == ST_HALT);
  assign state_o    = state_q;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Bench for subleq_ctrl: behavioural RAM, directed vector table, corner
// sequences and random programs checked against a sequential SUBLEQ model.
module tb_subleq_ctrl;
  import subleq_pkg::*;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RUN = 1'b0;
  logic [7:0]    addrA, addrB, addrC, dataC, PC;
  logic [7:0]    dataA = 8'h00;
  logic [7:0]    dataB = 8'h00;
  logic          WE, INSTR_DONE, HALTED;
  subleq_state_e state_dbg;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         we_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  subleq_ctrl #(
    .ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .HALT_ADDR(8'hFF)
  ) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN),
    .addrA(addrA), .addrB(addrB), .dataA(dataA), .dataB(dataB),
    .addrC(addrC), .dataC(dataC), .WE(WE),
    .PC(PC), .INSTR_DONE(INSTR_DONE), .HALTED(HALTED),
    .state_o(state_dbg)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Registered-read RAM; reads sample old contents before the write lands.
  always @(posedge CLK) begin
    dataA <= mem[addrA];
    dataB <= mem[addrB];
    if (WE) begin
      mem[addrC] = dataC;
      we_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    RUN = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // From FETCH, one full instruction is four edges.
  task automatic run_instr(output int done_cnt);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (INSTR_DONE) done_cnt++;
    end
  endtask

  // Reference model: one SUBLEQ instruction on ref_mem, plain integer arithmetic.
  task automatic model_step(inout int pc, inout bit halted);
    int a, b, c, va, vb, t, rs;
    logic [7:0] r;
    a  = ref_mem[pc];
    b  = ref_mem[(pc + 1) % 256];
    c  = ref_mem[(pc + 2) % 256];
    va = $signed(ref_mem[a]);
    vb = $signed(ref_mem[b]);
    t  = vb - va;
    r  = t[7:0];
    rs = $signed(r);
    ref_mem[b] = r;
    if (rs <= 0 && c == 255) halted = 1'b1;
    else if (rs <= 0)        pc = c;
    else                     pc = (pc + 3) % 256;
  endtask

  typedef struct {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] exp_res;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int d, we_before, ref_pc, mism;
    bit ref_halt;

    vecs[0] = '{8'h03, 8'h05, 8'h02, 8'h03};
    vecs[1] = '{8'h05, 8'h05, 8'h00, 8'h20};
    vecs[2] = '{8'h06, 8'h05, 8'hFF, 8'h20};
    vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'h03};
    vecs[4] = '{8'h01, 8'h00, 8'hFF, 8'h20};
    vecs[5] = '{8'h7F, 8'h80, 8'h01, 8'h03};
    vecs[6] = '{8'hFF, 8'h7F, 8'h80, 8'h20};
    vecs[7] = '{8'h00, 8'h01, 8'h01, 8'h03};

    // Reset behaviour
    clear_mem();
    RST = 1'b1;
    RUN = 1'b1;
    tick();
    check("rst_we", 32'(WE), 32'h0);
    check("rst_pc", 32'(PC), 32'h00);
    check("rst_halted", 32'(HALTED), 32'h0);
    check("rst_addrA", 32'(addrA), 32'h00);
    check("rst_addrB", 32'(addrB), 32'h01);
    check("rst_done", 32'(INSTR_DONE), 32'h0);
    tick();
    check("rst2_addrB", 32'(addrB), 32'h01);
    RST = 1'b0;
    tick();
    check("post_rst_we", 32'(WE), 32'h0);
    check("post_rst_pc", 32'(PC), 32'h00);
    check("post_rst_halted", 32'(HALTED), 32'h0);

    // Directed vectors: {10,11,20} at 0 with operands at 10/11
    for (int v = 0; v < 8; v++) begin
      clear_mem();
      mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h20;
      mem[8'h10] = vecs[v].opa;
      mem[8'h11] = vecs[v].opb;
      do_reset();
      run_instr(d);
      check($sformatf("vec%0d_res", v), 32'(mem[8'h11]), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d_pc", v), 32'(PC), 32'(vecs[v].exp_pc));
      check($sformatf("vec%0d_done", v), 32'(d), 32'd1);
      check($sformatf("vec%0d_opa_kept", v), 32'(mem[8'h10]), 32'(vecs[v].opa));
    end

    // Halt: {10,10,FF}
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h10; mem[2] = 8'hFF;
    mem[8'h10] = 8'h05;
    do_reset();
    tick(); tick(); tick();
    check("halt_exec_we", 32'(WE), 32'h1);
    check("halt_not_yet", 32'(HALTED), 32'h0);
    tick();
    check("halt_halted", 32'(HALTED), 32'h1);
    check("halt_mem", 32'(mem[8'h10]), 32'h00);
    we_before = we_cnt;
    repeat (20) tick();
    check("halt_no_we", 32'(we_cnt), 32'(we_before));
    check("halt_sticky", 32'(HALTED), 32'h1);
    check("halt_state", 32'(state_dbg), 32'(ST_HALT));

    // Wrap: branch to FE, then FE,FF,00 non-branching
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'hFE;
    mem[8'h20] = 8'h07;
    mem[8'hFE] = 8'h30; mem[8'hFF] = 8'h31;
    mem[8'h30] = 8'h01; mem[8'h31] = 8'h05;
    do_reset();
    run_instr(d);
    check("wrap_pc_fe", 32'(PC), 32'hFE);
    check("wrap_first_res", 32'(mem[8'h20]), 32'h00);
    tick();
    check("wrap_f1_addrA", 32'(addrA), 32'h00);
    check("wrap_f1_addrB", 32'(addrB), 32'h31);
    tick();
    check("wrap_f2_addrA", 32'(addrA), 32'h30);
    tick();
    check("wrap_exec_addrC", 32'(addrC), 32'h31);
    check("wrap_exec_dataC", 32'(dataC), 32'h04);
    tick();
    check("wrap_next_pc", 32'(PC), 32'h01);
    check("wrap_mem", 32'(mem[8'h31]), 32'h04);

    // Stall with RUN low, then RUN dropped mid-instruction
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h20;
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h05;
    RST = 1'b1; RUN = 1'b0;
    tick(); tick();
    RST = 1'b0;
    we_before = we_cnt;
    repeat (6) tick();
    check("stall_state", 32'(state_dbg), 32'(ST_FETCH));
    check("stall_pc", 32'(PC), 32'h00);
    check("stall_no_we", 32'(we_cnt), 32'(we_before));
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    tick(); tick();
    check("midrun_done", 32'(INSTR_DONE), 32'h1);
    tick();
    check("midrun_pc", 32'(PC), 32'h03);
    check("midrun_mem", 32'(mem[8'h11]), 32'h02);
    repeat (3) tick();
    check("midrun_held", 32'(state_dbg), 32'(ST_FETCH));
    check("midrun_pc_held", 32'(PC), 32'h03);

    // Reset asserted during EXEC suppresses the write
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h20;
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h05;
    do_reset();
    tick(); tick(); tick();
    check("rstexec_in_exec", 32'(INSTR_DONE), 32'h1);
    RST = 1'b1;
    #1;
    check("rstexec_we_gated", 32'(WE), 32'h0);
    tick();
    check("rstexec_mem", 32'(mem[8'h11]), 32'h05);
    check("rstexec_pc", 32'(PC), 32'h00);
    check("rstexec_state", 32'(state_dbg), 32'(ST_FETCH));
    RST = 1'b0;

    // Random programs against the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = 8'($urandom_range(0, 255));
        ref_mem[i] = mem[i];
      end
      do_reset();
      ref_pc   = 0;
      ref_halt = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (!ref_halt) begin
          run_instr(d);
          model_step(ref_pc, ref_halt);
          check($sformatf("rand%0d_pc%0d", r, k), 32'(PC), 32'(ref_pc));
          check($sformatf("rand%0d_halt%0d", r, k), 32'(HALTED), 32'(ref_halt));
        end
      end
      mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      check($sformatf("rand%0d_mem_diffs", r), 32'(mism), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/subleq_ctrl.md
# subleq_ctrl

Sequencing and execute unit for the SUBLEQ-OISC. It drives the two registered read ports and the synchronous write port of the 256×8 dual-port instruction/data RAM, and consumes the read data. It fetches the three-word instruction `a, b, c` at `PC` and computes `mem[b] <= mem[b] - mem[a]`. It branches to `c` when the result is ≤ 0 and otherwise advances `PC` by 3. It is the only master of the RAM in the processor.

## Interface
Parameters:
- `ADDR_W`, 8: RAM address width; also the `PC` width.
- `DATA_W`, 8: RAM word width; operands are two's-complement.
- `RESET_PC`, 8'h00: `PC` value after reset.
- `HALT_ADDR`, 8'hFF: a taken branch to this target halts the core.

Ports:
- `CLK` in 1: the only clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `RUN` in 1: when low, the core holds in `FETCH` and issues no new instruction.
- `addrA` out ADDR_W: RAM read port A address; the RAM registers it.
- `addrB` out ADDR_W: RAM read port B address; the RAM registers it.
- `dataA` in DATA_W: RAM read data A, valid the cycle after `addrA` is presented.
- `dataB` in DATA_W: RAM read data B, valid the cycle after `addrB` is presented.
- `addrC` out ADDR_W: RAM write address.
- `dataC` out DATA_W: RAM write data.
- `WE` out 1: RAM write strobe; the write commits on the `CLK` edge.
- `PC` out ADDR_W: current program counter.
- `INSTR_DONE` out 1: one-cycle pulse in the cycle of each `EXEC`.
- `HALTED` out 1: high from halt until reset.

## Operation
States: `FETCH`, `F1`, `F2`, `EXEC`, `HALT`. Addresses and `WE` are combinational from the state and registers. Data is captured on the edge that leaves a state.

- `FETCH`:
  - Drive `addrA=PC`, `addrB=PC+1`.
  - Go to `F1` if `RUN`, else stay in `FETCH`.
- `F1`:
  - Capture `a_ptr<=dataA`, `b_ptr<=dataB`.
  - Drive `addrA=PC+2`, `addrB=dataB`.
  - Go to `F2`.
- `F2`:
  - Capture `c_ptr<=dataA`, `opb<=dataB`.
  - Drive `addrA=a_ptr`.
  - Go to `EXEC`.
- `EXEC`:
  - `diff = opb - dataA`, truncated to `DATA_W`.
  - Drive `WE=1`, `addrC=b_ptr`, `dataC=diff`.
  - `leq = diff[DATA_W-1] | (diff==0)`, evaluated on the truncated result, not the true difference.
  - If `leq` and `c_ptr==HALT_ADDR`: go to `HALT`; the write still commits.
  - Else: `PC <= leq ? c_ptr : PC+3` (mod 2^ADDR_W), then go to `FETCH`.
- `HALT`: `WE=0`, `HALTED=1`; leave only through reset.
- In every state other than `EXEC`, `WE=0`.
- `WE` is gated by `!RST`, so a reset asserted during `EXEC` suppresses the write.
- In non-driving states, `addrA`, `addrB`, `addrC` and `dataC` hold `PC`, `PC+1`, 0 and 0 respectively.
- Reset values:
  - State `FETCH`, `PC=RESET_PC`.
  - `a_ptr`, `b_ptr`, `c_ptr` and `opb` are 0.
  - `WE=0`, `INSTR_DONE=0`, `HALTED=0`.
  - `addrA=RESET_PC`, `addrB=RESET_PC+1`.
- Wrap-around:
  - `PC+1`, `PC+2` and `PC+3` wrap modulo 256. For example, `PC=8'hFE` fetches `FE, FF, 00`, and the fall-through `PC` is `01`.
- Self-modifying code:
  - Because the write commits on the `EXEC→FETCH` edge, the next fetch sees the written value. No forwarding is required.
  - If `b` equals `PC+k`, the next instruction sees the updated word.
- `a==b`: the result is 0, so the branch is always taken.

## Timing
- Fixed 4 cycles per instruction (`FETCH`, `F1`, `F2`, `EXEC`) while `RUN` is high. No stalls beyond `RUN`.
- The RAM write is visible on the read ports from the `F1` of the next instruction.
- `PC` and `HALTED` are registered and update on the edge leaving `EXEC`.
- `INSTR_DONE` is high exactly during `EXEC`.
- `RUN` is sampled only in `FETCH`. Deasserting it mid-instruction does not abort that instruction.
- `RST` overrides everything on the next edge, in any state.

## Structure
- Package `subleq_pkg` holds:
  - the state enum;
  - `ADDR_W` and `DATA_W` defaults;
  - `HALT_ADDR` default;
  - the instruction-length constant 3.
- One sub-module, `subleq_alu`: combinational subtract plus `leq` flag (inputs `opb`, `opa`; outputs `diff`, `leq`).
- The FSM, pointer registers and `PC` stay in `subleq_ctrl`.
- Top-level integration connects the RAM ports one-to-one by name.

## Test plan
- Reset: hold `RST` 2 cycles with `RUN=1`, then release.
  - During reset and the cycle after: `WE=0`, `PC=00`, `HALTED=0`, `addrA=00`, `addrB=01`.
- Non-branching subtract:
  - `mem[00..02]={10,11,20}`, `mem[10]=03`, `mem[11]=05`.
  - Expect `mem[11]=02`, `PC=03` after 4 cycles, `INSTR_DONE` for exactly 1 cycle.
- Branch on zero and on negative:
  - `mem[10]=05`, `mem[11]=05` → `mem[11]=00`, `PC=20`.
  - `mem[10]=06`, `mem[11]=05` → `mem[11]=FF`, `PC=20`.
- Truncation:
  - `mem[11]=80`, `mem[10]=01` → `mem[11]=7F`, no branch, `PC=03`.
- Halt:
  - `{10,10,FF}` at `PC=00` → `mem[10]=00`, `HALTED=1` from cycle 5.
  - No further `WE` for 20 cycles.
- Wrap, stall and reset-in-`EXEC`:
  - `PC=FE` non-branching → operands fetched from `FE`, `FF`, `00`; next `PC=01`.
  - `RUN=0` holds the core in `FETCH`.
  - `RST` asserted during `EXEC` → no RAM write; `PC=00`.
